multich_trig_capture: RTL and testbench
=======================================

MULTICH_TRIG_CAPTURE -- requirements
Module: multich_trig_capture

Interface
REQ-001 SHALL have parameter NCH, default 2: number of ADC channels, 1..8.
REQ-002 SHALL have parameter DW, default 14: sample width per channel.
REQ-003 SHALL have parameter PRE, default 16: pre-trigger samples per window, 1..128.
REQ-004 SHALL have parameter POST, default 48: samples per window from the trigger sample onward, >=1.
REQ-005 SHALL have parameter HOLDOFF, default 8: dead cycles after window end, >=0.
REQ-006 SHALL have ports: clk  in  1  sample clock, one sample per channel per cycle; the block uses one clock.
REQ-007 SHALL have ports: rst  in  1  reset, synchronous and active-high.
REQ-008 SHALL have ports: enable  in  1  arm permission.
REQ-009 SHALL have ports: din  in  NCH*DW  packed samples, ch0 in LSBs, unsigned.
REQ-010 SHALL have ports: baseline  in  NCH*DW  packed per-channel baseline.
REQ-011 SHALL have ports: thres  in  DW  trigger threshold above baseline.
REQ-012 SHALL have ports: ch_mask  in  NCH  1 = channel participates in internal trigger.
REQ-013 SHALL have ports: mode  in  2  0 = internal OR, 1 = internal AND, 2 = external only, 3 = internal OR | external.
REQ-014 SHALL have ports: ext_trig  in  1  external trigger level; sw_trig  in  1  forced trigger pulse.
REQ-015 SHALL have ports: full  in  1  downstream buffer full.
REQ-016 SHALL have ports: o_valid  out  1; o_data  out  NCH*DW; o_sof  out  1; o_eof  out  1.
REQ-017 SHALL have ports: evt_cnt  out  16  accepted events; lost_cnt  out  16  rejected triggers; busy  out  1.

Function
REQ-018 SHALL hold per-channel over = (din_ch - baseline_ch) > thres, computed signed in DW+2 bits; din_ch <= baseline_ch never sets over.
REQ-019 SHALL detect per-channel rising edge: hit_ch = over_ch & ~over_ch(previous cycle) & ch_mask_ch.
REQ-020 SHALL form internal trigger: mode 0 = OR of hit; mode 1 = every masked channel over with at least one hit this cycle; ch_mask=0 gives no internal trigger.
REQ-021 SHALL form external trigger as rising edge of ext_trig; used in modes 2 and 3 only.
REQ-022 SHALL treat sw_trig high in ARMED as a trigger in any mode.
REQ-023 SHALL delay din through a PRE+1-deep pretrigger line per channel.
REQ-024 SHALL implement states FILL, ARMED, CAPTURE, HOLD.
REQ-025 SHALL in FILL count PRE+1 samples, then go to ARMED; triggers in FILL are ignored and not counted.
REQ-026 SHALL accept a trigger in ARMED only when enable=1 and full=0; trigger at cycle t -> CAPTURE at t+1.
REQ-027 SHALL, for trigger at t, drive o_valid=1 on cycles t+1..t+PRE+POST with o_data equal to din of cycles t-PRE..t+POST-1.
REQ-028 SHALL pulse o_sof on cycle t+1 only and o_eof on cycle t+PRE+POST only.
REQ-029 SHALL after o_eof enter HOLD for HOLDOFF cycles, then ARMED; HOLDOFF=0 goes directly to ARMED, next trigger accepted at t+PRE+POST+1.
REQ-030 SHALL increment evt_cnt on each accepted trigger, wrap at 16 bits.
REQ-031 SHALL increment lost_cnt, saturating at 16'hFFFF, for a trigger in CAPTURE or HOLD, or in ARMED with full=1; a simultaneous trigger source counts once.
REQ-032 SHALL complete a started window when enable drops or full rises mid-window; no truncation.
REQ-033 SHALL drive busy=1 in FILL, CAPTURE, HOLD; 0 in ARMED.
REQ-034 SHALL ignore trigger-source changes during CAPTURE; edge detectors keep updating every cycle.

Reset
REQ-035 SHALL on rst=1 set state FILL, clear fill counter, window counter, edge history, evt_cnt, lost_cnt.
REQ-036 SHALL on rst=1 drive o_valid=0, o_sof=0, o_eof=0, o_data=0, busy=1; pretrigger line contents need not be cleared.
REQ-037 SHALL abort an in-progress window on rst mid-capture; o_eof is not issued.

Verification
REQ-038 SHALL cover: NCH=2, PRE=16, POST=48, baseline=1000, thres=80, mode 0, ramp din; ch1 steps to 1081 at t -> o_valid t+1..t+64, first o_data = din(t-16), o_sof/o_eof single pulses, evt_cnt=1.
REQ-039 SHALL cover: mode 1, ch0 at 1081 and ch1 at 1050 -> no window; both at 1081 in the same cycle -> window, evt_cnt=1.
REQ-040 SHALL cover: second ch0 edge at t+10 and sw_trig at t+30 -> window unchanged, lost_cnt=2, evt_cnt=1.
REQ-041 SHALL cover: full=1 with ch0 edge in ARMED -> no o_valid, lost_cnt=1; full rising at t+5 during a window -> all 64 samples still output.
REQ-042 SHALL cover: rst=1 for one cycle at t+20 of a window -> o_valid=0 next cycle, counters 0, triggers ignored for next 17 cycles.
REQ-043 SHALL cover: HOLDOFF=0, mode 2, ext_trig rising at t and at t+65 -> two back-to-back windows, evt_cnt=2, lost_cnt=0.

Source files
------------

// File: rtl/multich_trig_capture.sv
// Multi-channel threshold trigger with pre-trigger history: on an accepted trigger
// streams PRE samples before and POST samples from the trigger cycle onward, all channels packed.
module multich_trig_capture #(
  parameter int NCH     = 2,
  parameter int DW      = 14,
  parameter int PRE     = 16,
  parameter int POST    = 48,
  parameter int HOLDOFF = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [NCH*DW-1:0] din,
  input  logic [NCH*DW-1:0] baseline,
  input  logic [DW-1:0]     thres,
  input  logic [NCH-1:0]    ch_mask,
  input  logic [1:0]        mode,
  input  logic              ext_trig,
  input  logic              sw_trig,
  input  logic              full,
  output logic              o_valid,
  output logic [NCH*DW-1:0] o_data,
  output logic              o_sof,
  output logic              o_eof,
  output logic [15:0]       evt_cnt,
  output logic [15:0]       lost_cnt,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {FILL = 2'd0, ARMED = 2'd1, CAPTURE = 2'd2, HOLD = 2'd3} state_t;

  localparam int WIN = PRE + POST;
  localparam int CW  = $clog2(WIN + HOLDOFF + 2);
  localparam int HOLD_LAST = (HOLDOFF == 0) ? 0 : HOLDOFF - 1;

  state_t            state, state_nx;
  logic [CW-1:0]     cnt, cnt_nx;
  logic [NCH-1:0]    over, over_q, hit;
  logic              ext_q, ext_edge;
  logic              int_or, int_and, trig;
  logic              accept, lost;
  logic [NCH*DW-1:0] line [PRE+1];

  // Baseline subtraction in DW+2 signed bits so a sample below baseline is negative, never over.
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic signed [DW+1:0] diff;
    assign diff    = $signed({2'b00, din[c*DW +: DW]}) - $signed({2'b00, baseline[c*DW +: DW]});
    assign over[c] = diff > $signed({2'b00, thres});
  end

  assign hit      = over & ~over_q & ch_mask;
  assign ext_edge = ext_trig & ~ext_q;

  always_comb begin
    int_or  = |hit;
    int_and = (ch_mask != '0) && ((over & ch_mask) == ch_mask) && (|hit);
    trig    = sw_trig;
    case (mode)
      2'd0:    trig = trig | int_or;
      2'd1:    trig = trig | int_and;
      2'd2:    trig = trig | ext_edge;
      default: trig = trig | int_or | ext_edge;
    endcase
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept   = 1'b0;
    lost     = 1'b0;
    case (state)
      FILL: begin
        if (cnt == CW'(PRE)) begin
          state_nx = ARMED;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      ARMED: begin
        if (trig && enable && !full) begin
          accept   = 1'b1;
          state_nx = CAPTURE;
          cnt_nx   = '0;
        end else if (trig && full) begin
          lost = 1'b1;
        end
      end
      CAPTURE: begin
        lost = trig;
        if (cnt == CW'(WIN - 1)) begin
          cnt_nx   = '0;
          state_nx = (HOLDOFF == 0) ? ARMED : HOLD;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: begin
        lost = trig;
        if (cnt == CW'(HOLD_LAST)) begin
          cnt_nx   = '0;
          state_nx = ARMED;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
    endcase
  end

  // line[k] holds din from k+1 cycles ago; line[PRE] is the oldest pre-trigger sample.
  always_ff @(posedge clk) begin
    line[0] <= din;
    for (int i = 1; i <= PRE; i++) line[i] <= line[i-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FILL;
      cnt      <= '0;
      over_q   <= '0;
      ext_q    <= 1'b0;
      evt_cnt  <= '0;
      lost_cnt <= '0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      over_q <= over;
      ext_q  <= ext_trig;
      if (accept) evt_cnt <= evt_cnt + 16'd1;
      if (lost && lost_cnt != 16'hFFFF) lost_cnt <= lost_cnt + 16'd1;
    end
  end

  // o_valid has no ready: full only blocks arming, so a started window always streams to its end.
  assign o_valid   = (state == CAPTURE);
  assign o_sof     = o_valid && (cnt == '0);
  assign o_eof     = o_valid && (cnt == CW'(WIN - 1));
  assign o_data    = o_valid ? line[PRE] : '0;
  assign busy      = (state != ARMED);
  assign dbg_state = state;

endmodule

// File: tb/tb_multich_trig_capture.sv
// Directed bench for multich_trig_capture: scoreboard of {sof, eof, data} built from the driven samples.
module tb_multich_trig_capture;

  localparam int NCH = 2, DW = 14, PRE = 16, POST = 48, HO = 8;
  localparam int DWD = NCH * DW;
  localparam int W   = DWD + 2;

  logic           clk = 1'b0;
  logic           rst, enable, ext_trig, sw_trig, full;
  logic [DWD-1:0] din, baseline;
  logic [DW-1:0]  thres;
  logic [NCH-1:0] ch_mask;
  logic [1:0]     mode;

  logic           a_valid, a_sof, a_eof, a_busy, b_valid, b_sof, b_eof, b_busy;
  logic [DWD-1:0] a_data, b_data;
  logic [15:0]    a_evt, a_lost, b_evt, b_lost;
  logic [1:0]     a_state, b_state;

  logic           sel_b = 1'b0;
  logic           obs_valid, obs_sof, obs_eof, obs_busy;
  logic [DWD-1:0] obs_data;
  logic [15:0]    obs_evt, obs_lost;
  logic [1:0]     obs_state;

  logic [W-1:0]   exp_q[$];
  logic [DWD-1:0] hist[$];
  int             win_rem = 0;
  int             cyc = 0;
  int             n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  multich_trig_capture #(.NCH(NCH), .DW(DW), .PRE(PRE), .POST(POST), .HOLDOFF(HO)) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .din(din), .baseline(baseline), .thres(thres),
    .ch_mask(ch_mask), .mode(mode), .ext_trig(ext_trig), .sw_trig(sw_trig), .full(full),
    .o_valid(a_valid), .o_data(a_data), .o_sof(a_sof), .o_eof(a_eof),
    .evt_cnt(a_evt), .lost_cnt(a_lost), .busy(a_busy), .dbg_state(a_state));

  multich_trig_capture #(.NCH(NCH), .DW(DW), .PRE(PRE), .POST(POST), .HOLDOFF(0)) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .din(din), .baseline(baseline), .thres(thres),
    .ch_mask(ch_mask), .mode(mode), .ext_trig(ext_trig), .sw_trig(sw_trig), .full(full),
    .o_valid(b_valid), .o_data(b_data), .o_sof(b_sof), .o_eof(b_eof),
    .evt_cnt(b_evt), .lost_cnt(b_lost), .busy(b_busy), .dbg_state(b_state));

  assign obs_valid = sel_b ? b_valid : a_valid;
  assign obs_data  = sel_b ? b_data  : a_data;
  assign obs_sof   = sel_b ? b_sof   : a_sof;
  assign obs_eof   = sel_b ? b_eof   : a_eof;
  assign obs_busy  = sel_b ? b_busy  : a_busy;
  assign obs_evt   = sel_b ? b_evt   : a_evt;
  assign obs_lost  = sel_b ? b_lost  : a_lost;
  assign obs_state = sel_b ? b_state : a_state;

  function automatic logic [DW-1:0] ic0(input int k);
    return DW'(900 + k % 64);
  endfunction

  function automatic logic [DW-1:0] ic1(input int k);
    return DW'(800 + (k * 3) % 64);
  endfunction

  function automatic logic [DWD-1:0] mk(input logic [DW-1:0] c0, input logic [DW-1:0] c1);
    return {c1, c0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Checks the outputs of the current cycle, records din into the model, then advances one clock.
  task automatic tick(input bit trig);
    logic [W-1:0] e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("o_valid", 32'(obs_valid), 32'd1);
      chk("o_data", 32'(obs_data), 32'(e[DWD-1:0]));
      chk("o_sof", 32'(obs_sof), 32'(e[W-1]));
      chk("o_eof", 32'(obs_eof), 32'(e[W-2]));
    end else begin
      chk("o_valid_idle", 32'(obs_valid), 32'd0);
      chk("o_sof_idle", 32'(obs_sof), 32'd0);
      chk("o_eof_idle", 32'(obs_eof), 32'd0);
    end
    if (trig) begin
      for (int i = 0; i < hist.size(); i++) exp_q.push_back({(i == 0), 1'b0, hist[i]});
      exp_q.push_back({1'b0, (POST == 1), din});
      win_rem = POST - 1;
    end else if (win_rem > 0) begin
      win_rem--;
      exp_q.push_back({1'b0, (win_rem == 0), din});
    end
    hist.push_back(din);
    if (hist.size() > PRE) void'(hist.pop_front());
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      din = mk(ic0(cyc), ic1(cyc));
      tick(1'b0);
    end
  endtask

  task automatic do_reset();
    din = mk(ic0(cyc), ic1(cyc));
    rst = 1'b1;
    tick(1'b0);
    rst = 1'b0;
    exp_q.delete();
    win_rem = 0;
    chk("rst_valid", 32'(obs_valid), 32'd0);
    chk("rst_data", 32'(obs_data), 32'd0);
    chk("rst_sof_eof", 32'({obs_sof, obs_eof}), 32'd0);
    chk("rst_busy", 32'(obs_busy), 32'd1);
    chk("rst_evt", 32'(obs_evt), 32'd0);
    chk("rst_lost", 32'(obs_lost), 32'd0);
    chk("rst_state", 32'(obs_state), 32'd0);
    run(PRE + 1);
    chk("armed_busy", 32'(obs_busy), 32'd0);
    chk("armed_state", 32'(obs_state), 32'd1);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; ext_trig = 1'b0; sw_trig = 1'b0; full = 1'b0;
    baseline = mk(DW'(1000), DW'(1000));
    thres = DW'(80); ch_mask = 2'b11; mode = 2'd0;
    din = mk(ic0(0), ic1(0));
    repeat (2) @(posedge clk);
    #1;

    // Reset values, and a trigger during FILL that must be ignored.
    din = mk(ic0(cyc), ic1(cyc));
    tick(1'b0);
    rst = 1'b0;
    chk("init_busy", 32'(obs_busy), 32'd1);
    chk("init_evt", 32'(obs_evt), 32'd0);
    run(4);
    din = mk(ic0(cyc), DW'(1081));
    tick(1'b0);
    chk("fill_busy", 32'(obs_busy), 32'd1);
    run(PRE + 1 - 5);
    chk("fill_done_busy", 32'(obs_busy), 32'd0);
    chk("fill_trig_lost", 32'(obs_lost), 32'd0);
    chk("fill_trig_evt", 32'(obs_evt), 32'd0);

    // Mode 0: ch1 step to 1081 opens one window.
    run(3);
    din = mk(ic0(cyc), DW'(1081));
    tick(1'b1);
    chk("capture_busy", 32'(obs_busy), 32'd1);
    for (int j = 1; j < 10; j++) begin
      din = mk(ic0(cyc), DW'(1081));
      tick(1'b0);
    end
    run(PRE + POST + HO + 2 - 10);
    chk("m0_evt", 32'(obs_evt), 32'd1);
    chk("m0_lost", 32'(obs_lost), 32'd0);
    chk("m0_busy", 32'(obs_busy), 32'd0);

    // Mode 1: partial coincidence rejected, full coincidence accepted.
    do_reset();
    mode = 2'd1;
    for (int j = 0; j < 3; j++) begin
      din = mk(DW'(1081), DW'(1050));
      tick(1'b0);
    end
    run(3);
    chk("m1_partial_evt", 32'(obs_evt), 32'd0);
    din = mk(DW'(1081), DW'(1081));
    tick(1'b1);
    din = mk(DW'(1081), DW'(1081));
    tick(1'b0);
    run(PRE + POST + HO + 2);
    chk("m1_evt", 32'(obs_evt), 32'd1);
    chk("m1_lost", 32'(obs_lost), 32'd0);

    // Triggers during CAPTURE are counted as lost and leave the window intact.
    do_reset();
    mode = 2'd0;
    din = mk(DW'(1081), ic1(cyc));
    tick(1'b1);
    for (int j = 1; j < PRE + POST + HO + 3; j++) begin
      din = mk((j == 10) ? DW'(1081) : ic0(cyc), ic1(cyc));
      sw_trig = (j == 30);
      tick(1'b0);
    end
    sw_trig = 1'b0;
    chk("cap_lost", 32'(obs_lost), 32'd2);
    chk("cap_evt", 32'(obs_evt), 32'd1);

    // full blocks arming and counts as lost; enable=0 blocks silently; full mid-window does not truncate.
    do_reset();
    full = 1'b1;
    din = mk(DW'(1081), ic1(cyc));
    tick(1'b0);
    run(2);
    full = 1'b0;
    enable = 1'b0;
    din = mk(DW'(1081), ic1(cyc));
    tick(1'b0);
    run(2);
    enable = 1'b1;
    chk("full_lost", 32'(obs_lost), 32'd1);
    chk("full_evt", 32'(obs_evt), 32'd0);
    din = mk(DW'(1081), ic1(cyc));
    tick(1'b1);
    for (int j = 1; j < PRE + POST + HO + 3; j++) begin
      full = (j >= 5);
      din = mk(ic0(cyc), ic1(cyc));
      tick(1'b0);
    end
    chk("full_mid_evt", 32'(obs_evt), 32'd1);
    chk("full_mid_lost", 32'(obs_lost), 32'd1);
    full = 1'b0;

    // Reset in mid-window aborts it; triggers ignored while refilling.
    do_reset();
    din = mk(ic0(cyc), DW'(1081));
    tick(1'b1);
    run(19);
    din = mk(ic0(cyc), ic1(cyc));
    rst = 1'b1;
    tick(1'b0);
    rst = 1'b0;
    exp_q.delete();
    win_rem = 0;
    chk("abort_valid", 32'(obs_valid), 32'd0);
    chk("abort_eof", 32'(obs_eof), 32'd0);
    chk("abort_evt", 32'(obs_evt), 32'd0);
    chk("abort_lost", 32'(obs_lost), 32'd0);
    for (int j = 1; j <= PRE + 1; j++) begin
      chk("refill_busy", 32'(obs_busy), 32'd1);
      din = mk((j == 3) ? DW'(1081) : ic0(cyc), ic1(cyc));
      sw_trig = (j == 8);
      tick(1'b0);
    end
    sw_trig = 1'b0;
    chk("refill_armed", 32'(obs_busy), 32'd0);
    chk("refill_evt", 32'(obs_evt), 32'd0);
    chk("refill_lost", 32'(obs_lost), 32'd0);

    // Mode 2 on HOLDOFF=0: back-to-back windows; the HOLDOFF=8 unit loses the second.
    sel_b = 1'b1;
    mode = 2'd2;
    do_reset();
    run(2);
    din = mk(DW'(1081), ic1(cyc));
    tick(1'b0);
    run(2);
    chk("m2_internal_ignored", 32'(obs_evt), 32'd0);
    for (int j = 0; j < 2 * (PRE + POST) + 3; j++) begin
      ext_trig = (j < 4) || (j == PRE + POST + 1) || (j == PRE + POST + 2);
      din = mk(ic0(cyc), ic1(cyc));
      tick((j == 0) || (j == PRE + POST + 1));
    end
    ext_trig = 1'b0;
    run(3);
    chk("b2b_evt", 32'(obs_evt), 32'd2);
    chk("b2b_lost", 32'(obs_lost), 32'd0);
    chk("hold_unit_evt", 32'(a_evt), 32'd1);
    chk("hold_unit_lost", 32'(a_lost), 32'd1);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
